data_memory_stage: RTL and testbench

Memory-stage data path of the five-stage MIPS pipeline: a synchronous, byte-addressable data RAM with byte/halfword/word stores and sign/zero-extended loads. It consumes the M-stage address (ALU_result_M), store data and access controls. Formatted load data is presented as ReadData_W in the following cycle, aligned with the memory-to-writeback pipeline register outputs. Load data is therefore never carried through that register.

---
 rtl/data_memory_stage_pkg.sv | 25 ++
 rtl/data_memory_stage_if.sv | 23 ++
 rtl/data_memory_stage_load_aligner.sv | 32 +++
 rtl/data_memory_stage.sv | 105 ++++++++++
 tb/tb_data_memory_stage.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/data_memory_stage_pkg.sv
// Shared encodings for the memory stage: ByteControl bit positions and the
// access-size type used by the decoder, hazard unit and pipeline registers.
package data_memory_stage_pkg;

  localparam int unsigned BC_BYTE     = 0;
  localparam int unsigned BC_HALF     = 1;
  localparam int unsigned BC_WORD     = 2;
  localparam int unsigned BC_UNSIGNED = 3;

  typedef enum logic [1:0] {
    SzNone = 2'd0,
    SzByte = 2'd1,
    SzHalf = 2'd2,
    SzWord = 2'd3
  } size_e;

  // Word beats half beats byte; no size bit set means a no-op access.
  function automatic size_e decode_size(input logic [3:0] bc);
    if (bc[BC_WORD]) return SzWord;
    if (bc[BC_HALF]) return SzHalf;
    if (bc[BC_BYTE]) return SzByte;
    return SzNone;
  endfunction

endpackage

// File: rtl/data_memory_stage_if.sv
// M-stage access bus into the data memory and the W-stage load result.
interface data_memory_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             EN;
  logic             MemRead_M;
  logic             MemWrite_M;
  logic [3:0]       ByteControl_M;
  logic [WIDTH-1:0] ALU_result_M;
  logic [WIDTH-1:0] WriteData_M;
  logic             MisAlign_M;
  logic [WIDTH-1:0] ReadData_W;

  modport master (
    output EN, MemRead_M, MemWrite_M, ByteControl_M, ALU_result_M, WriteData_M,
    input  MisAlign_M, ReadData_W
  );

  modport slave (
    input  EN, MemRead_M, MemWrite_M, ByteControl_M, ALU_result_M, WriteData_M,
    output MisAlign_M, ReadData_W
  );
endinterface

// File: rtl/data_memory_stage_load_aligner.sv
// Combinational load formatting: picks the byte/half/word out of the RAM word
// and sign- or zero-extends it; returns 0 when the load is not valid.
module data_memory_stage_load_aligner
  import data_memory_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic        valid,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{off, 3'b000} +: 8];
  assign half_v = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    if (valid) begin
      unique case (size)
        SzByte:  data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        SzHalf:  data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        SzWord:  data = word;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_stage.sv
// Memory-stage data path: byte-addressable synchronous RAM with sized stores and
// a registered read whose formatted result appears as ReadData_W one cycle later.
module data_memory_stage
  import data_memory_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_stage_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];

  size_e             size;
  logic [1:0]        off;
  logic [ADDR_W-1:0] idx;
  logic              misalign;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic              we;
  logic              load_valid_d;

  logic [31:0]       rd_word_q;
  logic [1:0]        off_q;
  size_e             size_q;
  logic              unsigned_q;
  logic              load_valid_q;

  // Upper address bits are ignored so accesses wrap modulo the RAM size.
  logic              unused_addr;
  assign unused_addr = ^bus.ALU_result_M[WIDTH-1:ADDR_W+2];

  assign size = decode_size(bus.ByteControl_M);
  assign off  = bus.ALU_result_M[1:0];
  assign idx  = bus.ALU_result_M[ADDR_W+1:2];

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wlanes   = bus.WriteData_M;
    unique case (size)
      SzByte: begin
        be     = 4'b0001 << off;
        wlanes = {4{bus.WriteData_M[7:0]}};
      end
      SzHalf: begin
        misalign = off[0];
        be       = off[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{bus.WriteData_M[15:0]}};
      end
      SzWord: begin
        misalign = (off != 2'b00);
        be       = 4'b1111;
      end
      default: ;
    endcase
    misalign = misalign & (bus.MemRead_M | bus.MemWrite_M);
  end

  assign bus.MisAlign_M = misalign;
  assign we           = bus.EN & bus.MemWrite_M & ~misalign & (size != SzNone);
  assign load_valid_d = bus.MemRead_M & ~misalign & (size != SzNone);

  // Read-first: the registered read sees the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (bus.EN) begin
      rd_word_q <= mem[idx];
    end
    if (we && rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q        <= 2'b00;
      size_q       <= SzNone;
      unsigned_q   <= 1'b0;
      load_valid_q <= 1'b0;
    end else if (bus.EN) begin
      off_q        <= off;
      size_q       <= size;
      unsigned_q   <= bus.ByteControl_M[BC_UNSIGNED];
      load_valid_q <= load_valid_d;
    end
  end

  data_memory_stage_load_aligner u_load_aligner (
    .word        (rd_word_q),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .valid       (load_valid_q),
    .data        (bus.ReadData_W)
  );

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed vector bench for data_memory_stage: stores/loads of all sizes,
// misalignment, wrap-around, stall hold and asynchronous reset.
module tb_data_memory_stage;

  logic clk;
  logic rst_n;

  data_memory_stage_if #(.WIDTH(32)) bus ();

  data_memory_stage #(
    .WIDTH       (32),
    .DEPTH_WORDS (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rd;
    logic        wr;
    logic [3:0]  bc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_mis;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [3:0] bc, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic exp_mis,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.en = 1'b1; v.rd = rd; v.wr = wr; v.bc = bc; v.addr = addr; v.wdata = wdata;
    v.exp_mis = exp_mis; v.exp_rd = exp_rd; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rd, input logic wr, input logic [3:0] bc,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.EN = en; bus.MemRead_M = rd; bus.MemWrite_M = wr; bus.ByteControl_M = bc;
    bus.ALU_result_M = addr; bus.WriteData_M = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // bc: 1 byte, 2 half, 4 word, +8 unsigned
    vecs.push_back(mk("sw_10",        0, 1, 4'h4, 32'h10,   32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk("lw_10",        1, 0, 4'h4, 32'h10,   32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk("sb_13",        0, 1, 4'h1, 32'h13,   32'h000000A5, 0, 32'h0));
    vecs.push_back(mk("lb_13",        1, 0, 4'h1, 32'h13,   32'h0,        0, 32'hFFFFFFA5));
    vecs.push_back(mk("lbu_13",       1, 0, 4'h9, 32'h13,   32'h0,        0, 32'h000000A5));
    vecs.push_back(mk("lw_10_b",      1, 0, 4'h4, 32'h10,   32'h0,        0, 32'hA5ADBEEF));
    vecs.push_back(mk("sw_20",        0, 1, 4'h4, 32'h20,   32'h11223344, 0, 32'h0));
    vecs.push_back(mk("sh_22",        0, 1, 4'h2, 32'h22,   32'h00008001, 0, 32'h0));
    vecs.push_back(mk("lh_22",        1, 0, 4'h2, 32'h22,   32'h0,        0, 32'hFFFF8001));
    vecs.push_back(mk("lhu_22",       1, 0, 4'hA, 32'h22,   32'h0,        0, 32'h00008001));
    vecs.push_back(mk("lw_22_mis",    1, 0, 4'h4, 32'h22,   32'h0,        1, 32'h0));
    vecs.push_back(mk("sh_21_mis",    0, 1, 4'h2, 32'h21,   32'h0000FFFF, 1, 32'h0));
    vecs.push_back(mk("lw_20",        1, 0, 4'h4, 32'h20,   32'h0,        0, 32'h80013344));
    vecs.push_back(mk("lh_20",        1, 0, 4'h2, 32'h20,   32'h0,        0, 32'h00003344));
    vecs.push_back(mk("lb_21",        1, 0, 4'h1, 32'h21,   32'h0,        0, 32'h00000033));
    vecs.push_back(mk("lb_23",        1, 0, 4'h1, 32'h23,   32'h0,        0, 32'hFFFFFF80));
    vecs.push_back(mk("lbu_23",       1, 0, 4'h9, 32'h23,   32'h0,        0, 32'h00000080));
    vecs.push_back(mk("ld_nosize",    1, 0, 4'h8, 32'h10,   32'h0,        0, 32'h0));
    vecs.push_back(mk("st_nosize",    0, 1, 4'h0, 32'h10,   32'h0,        0, 32'h0));
    vecs.push_back(mk("lw_10_c",      1, 0, 4'h4, 32'h10,   32'h0,        0, 32'hA5ADBEEF));
    vecs.push_back(mk("rw_wrap_1010", 1, 1, 4'h4, 32'h1010, 32'hCAFEF00D, 0, 32'hA5ADBEEF));
    vecs.push_back(mk("lw_10_ubit",   1, 0, 4'hC, 32'h10,   32'h0,        0, 32'hCAFEF00D));
    vecs.push_back(mk("lb_11",        1, 0, 4'h1, 32'h11,   32'h0,        0, 32'hFFFFFFF0));
    vecs.push_back(mk("idle_half_o1", 0, 0, 4'h2, 32'h21,   32'h0,        0, 32'h0));
    vecs.push_back(mk("lw_noread",    0, 0, 4'h4, 32'h10,   32'h0,        0, 32'h0));
    vecs.push_back(mk("sb_12_repl",   0, 1, 4'h1, 32'h12,   32'h1234567F, 0, 32'h0));
    vecs.push_back(mk("lw_10_d",      1, 0, 4'h4, 32'h10,   32'h0,        0, 32'hCA7FF00D));
    vecs.push_back(mk("lh_12",        1, 0, 4'h2, 32'h12,   32'h0,        0, 32'hFFFFCA7F));

    #3;
    check("reset_rd", bus.ReadData_W, 32'h0);
    tick();
    check("reset_rd_hold", bus.ReadData_W, 32'h0);
    #3 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].rd, vecs[i].wr, vecs[i].bc, vecs[i].addr, vecs[i].wdata);
      #1;
      check({vecs[i].name, "_mis"}, {31'b0, bus.MisAlign_M}, {31'b0, vecs[i].exp_mis});
      tick();
      check({vecs[i].name, "_rd"}, bus.ReadData_W, vecs[i].exp_rd);
    end

    // Stall: loads and stores with EN low change neither ReadData_W nor memory.
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h4, 32'h20, 32'h0);
      tick();
      check("stall_ld_hold", bus.ReadData_W, 32'hFFFFCA7F);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b1, 4'h4, 32'h10, 32'h00000000);
      tick();
      check("stall_st_hold", bus.ReadData_W, 32'hFFFFCA7F);
    end
    drive(1'b1, 1'b1, 1'b0, 4'h4, 32'h10, 32'h0);
    tick();
    check("after_stall_lw_10", bus.ReadData_W, 32'hCA7FF00D);

    // Asynchronous reset mid-cycle, with a store held on the bus throughout.
    drive(1'b1, 1'b1, 1'b0, 4'h4, 32'h20, 32'h0);
    tick();
    check("pre_reset_lw_20", bus.ReadData_W, 32'h80013344);
    drive(1'b1, 1'b0, 1'b1, 4'h4, 32'h20, 32'h00000000);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rd", bus.ReadData_W, 32'h0);
    tick();
    tick();
    check("in_reset_rd", bus.ReadData_W, 32'h0);
    #3 rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'h4, 32'h20, 32'h0);
    tick();
    check("post_reset_lw_20", bus.ReadData_W, 32'h80013344);
    drive(1'b1, 1'b1, 1'b0, 4'h4, 32'h10, 32'h0);
    tick();
    check("post_reset_lw_10", bus.ReadData_W, 32'hCA7FF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
